// File: rtl/tb_intr_gen_mc.sv
// Multi-channel random interrupt generator: per-channel LFSR delay, level/ack or pulse mode, ack-timeout flag.
// Optional total-assertion counter enabled by defining TB_INTR_GEN_CNT_EN.

module tb_intr_gen_mc_ch #(
   parameter logic [15:0] Seed       = 16'h0001,
   parameter int unsigned PulseW     = 4,
   parameter int unsigned AckTimeout = 1024
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       en_i,
   input  logic [3:0] intvl_i,
   input  logic       mode_i,
   input  logic       ack_i,
`ifdef TB_INTR_GEN_CNT_EN
   output logic       start_o,
`endif
   output logic       irq_o,
   output logic       busy_o,
   output logic       err_o
);
   localparam int unsigned AW = ($clog2(AckTimeout + 1) > 4) ? $clog2(AckTimeout + 1) : 4;

   typedef enum logic [1:0] {IDLE, WAIT, ASSERT, COOL} state_t;

   state_t         st;
   logic [15:0]    lfsr;
   logic [7:0]     cnt;
   logic [7:0]     dly;
   logic [AW-1:0]  acnt;
   logic           mode_q;
   logic           go;

   assign go     = en_i && (intvl_i != 4'h0);
   assign dly    = {intvl_i, 4'h0} + {4'h0, lfsr[3:0]};
   assign busy_o = (st != IDLE);
`ifdef TB_INTR_GEN_CNT_EN
   assign start_o = (st == WAIT) && go && (cnt == 8'd1);
`endif

   // acnt is shared: pulse hold time in pulse mode, ack wait (saturating) in level mode
   always_ff @(posedge clk_i or posedge rst_ni) begin
      if (rst_ni) begin
         st     <= IDLE;
         lfsr   <= Seed;
         cnt    <= '0;
         acnt   <= '0;
         mode_q <= 1'b0;
         irq_o  <= 1'b0;
         err_o  <= 1'b0;
      end else begin
         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         case (st)
            IDLE: begin
               if (go) begin
                  st  <= WAIT;
                  cnt <= dly;
               end
            end
            WAIT: begin
               if (!go) begin
                  st <= IDLE;
               end else if (cnt == 8'd1) begin
                  st     <= ASSERT;
                  irq_o  <= 1'b1;
                  mode_q <= mode_i;
                  acnt   <= '0;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            ASSERT: begin
               if (mode_q) begin
                  if (acnt == AW'(PulseW - 1)) begin
                     st    <= COOL;
                     irq_o <= 1'b0;
                  end else begin
                     acnt <= acnt + AW'(1);
                  end
               end else if (ack_i) begin
                  st    <= COOL;
                  irq_o <= 1'b0;
               end else if (acnt != AW'(AckTimeout)) begin
                  acnt <= acnt + AW'(1);
                  if (acnt == AW'(AckTimeout - 1)) err_o <= 1'b1;
               end
            end
            COOL: begin
               if (go) begin
                  st  <= WAIT;
                  cnt <= dly;
               end else begin
                  st <= IDLE;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule

module tb_intr_gen_mc #(
   parameter int unsigned NCh        = 3,
   parameter logic [15:0] LfsrSeed   = 16'hACE1,
   parameter int unsigned PulseW     = 4,
   parameter int unsigned AckTimeout = 1024
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [4*NCh-1:0] intvl_i,
   input  logic [NCh-1:0]   mode_i,
   input  logic [NCh-1:0]   ack_i,
   output logic [NCh-1:0]   irq_o,
   output logic             active_o,
   output logic [NCh-1:0]   err_o,
   output logic [31:0]      irq_cnt_o
);
   logic [NCh-1:0] busy;
`ifdef TB_INTR_GEN_CNT_EN
   logic [NCh-1:0] start;
`endif

   for (genvar c = 0; c < NCh; c++) begin : g_ch
      // an all-zero seed would lock the LFSR
      localparam logic [15:0] SeedX = LfsrSeed ^ 16'(c + 1);
      localparam logic [15:0] Seed  = (SeedX == 16'h0000) ? 16'h0001 : SeedX;

      tb_intr_gen_mc_ch #(
         .Seed       (Seed),
         .PulseW     (PulseW),
         .AckTimeout (AckTimeout)
      ) u_ch (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .en_i    (en_i),
         .intvl_i (intvl_i[4*c +: 4]),
         .mode_i  (mode_i[c]),
         .ack_i   (ack_i[c]),
`ifdef TB_INTR_GEN_CNT_EN
         .start_o (start[c]),
`endif
         .irq_o   (irq_o[c]),
         .busy_o  (busy[c]),
         .err_o   (err_o[c])
      );
   end

   assign active_o = |busy;

`ifdef TB_INTR_GEN_CNT_EN
   logic [4:0]  nstart;
   logic [32:0] sum;

   always_comb begin
      nstart = '0;
      for (int c = 0; c < NCh; c++) nstart = nstart + 5'(start[c]);
   end

   assign sum = {1'b0, irq_cnt_o} + 33'(nstart);

   always_ff @(posedge clk_i or posedge rst_ni) begin
      if (rst_ni) irq_cnt_o <= '0;
      else        irq_cnt_o <= sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   end
`else
   assign irq_cnt_o = 32'h0;
`endif
endmodule

// File: tb/tb_tb_intr_gen_mc.sv
// Bench for tb_intr_gen_mc: event-time reference model feeds a scoreboard of irq/err edges, monitor compares.
// Counter expectation follows TB_INTR_GEN_CNT_EN.

module tb_tb_intr_gen_mc;
   localparam int NCH = 3;
   localparam int PW  = 4;
   localparam int ATO = 64;
   localparam logic [15:0] SEED = 16'hACE1;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b1;
   logic             en_i = 1'b0;
   logic [4*NCH-1:0] intvl_i = '0;
   logic [NCH-1:0]   mode_i = '0;
   logic [NCH-1:0]   ack_i;
   logic [NCH-1:0]   irq_o;
   logic             active_o;
   logic [NCH-1:0]   err_o;
   logic [31:0]      irq_cnt_o;

   always #5 clk_i = ~clk_i;

   tb_intr_gen_mc #(.NCh(NCH), .LfsrSeed(SEED), .PulseW(PW), .AckTimeout(ATO)) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .en_i      (en_i),
      .intvl_i   (intvl_i),
      .mode_i    (mode_i),
      .ack_i     (ack_i),
      .irq_o     (irq_o),
      .active_o  (active_o),
      .err_o     (err_o),
      .irq_cnt_o (irq_cnt_o)
   );

   int checks = 0;
   int errors = 0;

   // kind: 0 = irq rise, 1 = irq fall, 2 = err set
   typedef struct { int ch; int kind; int cyc; } ev_t;
   ev_t sbq[$];

   // reference model: phases 0 idle, 1 waiting, 2 asserted, 3 cool; times are absolute cycles
   int          cyc = 0;
   int          ph[NCH];
   int          due[NCH];
   int          rise_at[NCH];
   bit          lm[NCH];
   bit          merr[NCH];
   logic [15:0] ml[NCH];
   longint      mcount;
   int          amode[NCH];   // 0 never ack, 1 ack after 4 high cycles, 2 tied high, 3 random

   function automatic logic [15:0] seed_of(int c);
      logic [15:0] s;
      s = SEED ^ 16'(c + 1);
      return (s == 16'h0) ? 16'h0001 : s;
   endfunction

   function automatic logic [15:0] lstep(logic [15:0] x);
      return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
   endfunction

   function automatic void push(int c, int k, int t);
      ev_t e;
      e.ch = c; e.kind = k; e.cyc = t;
      sbq.push_back(e);
   endfunction

   always @(posedge clk_i) begin
      if (rst_ni) begin
         for (int c = 0; c < NCH; c++) begin
            ph[c] = 0; merr[c] = 1'b0; ml[c] = seed_of(c);
         end
         mcount = 0;
         sbq.delete();
      end else begin
         cyc++;
         for (int c = 0; c < NCH; c++) begin
            bit go;
            int d;
            go = en_i && (intvl_i[4*c +: 4] != 4'h0);
            d  = int'(intvl_i[4*c +: 4]) * 16 + int'(ml[c][3:0]);
            case (ph[c])
               0: if (go) begin ph[c] = 1; due[c] = cyc + d; end
               1: begin
                  if (!go) ph[c] = 0;
                  else if (cyc == due[c]) begin
                     ph[c] = 2; lm[c] = mode_i[c]; rise_at[c] = cyc; mcount++; push(c, 0, cyc);
                  end
               end
               2: begin
                  if (lm[c]) begin
                     if (cyc - rise_at[c] == PW) begin ph[c] = 3; push(c, 1, cyc); end
                  end else if (ack_i[c]) begin
                     ph[c] = 3; push(c, 1, cyc);
                  end else if (cyc - rise_at[c] == ATO && !merr[c]) begin
                     merr[c] = 1'b1; push(c, 2, cyc);
                  end
               end
               default: begin
                  if (go) begin ph[c] = 1; due[c] = cyc + d; end
                  else ph[c] = 0;
               end
            endcase
            ml[c] = lstep(ml[c]);
         end
      end
   end

   // monitor: every observed edge of irq_o/err_o must match the next scoreboard entry
   logic [NCH-1:0] pirq, perr;

   task automatic check_ev(int c, int k);
      ev_t e;
      checks++;
      if (sbq.size() == 0) begin
         errors++;
         $display("FAIL sb_unexpected ch%0d kind%0d at cycle %0d: got an edge, expected none", c, k, cyc);
      end else begin
         e = sbq.pop_front();
         if (e.ch != c || e.kind != k || e.cyc != cyc) begin
            errors++;
            $display("FAIL sb_edge: got ch%0d kind%0d cyc%0d, expected ch%0d kind%0d cyc%0d",
                     c, k, cyc, e.ch, e.kind, e.cyc);
         end
      end
   endtask

   always @(negedge clk_i) begin
      bit ma;
      if (rst_ni) begin
         pirq = irq_o; perr = err_o;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (irq_o[c] !== pirq[c]) check_ev(c, irq_o[c] ? 0 : 1);
            if (err_o[c] !== perr[c]) check_ev(c, 2);
         end
         while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            checks++; errors++;
            $display("FAIL sb_missed: got no edge, expected ch%0d kind%0d at cycle %0d",
                     sbq[0].ch, sbq[0].kind, sbq[0].cyc);
            void'(sbq.pop_front());
         end
         ma = 1'b0;
         for (int c = 0; c < NCH; c++) if (ph[c] != 0) ma = 1'b1;
         checks++;
         if (active_o !== ma) begin
            errors++;
            $display("FAIL active cycle %0d: got %0b expected %0b", cyc, active_o, ma);
         end
         pirq = irq_o; perr = err_o;
      end
   end

   // ack driver standing in for the memory model MMIO
   int hc[NCH];
   always @(negedge clk_i) begin
      logic [NCH-1:0] a;
      a = '0;
      for (int c = 0; c < NCH; c++) begin
         if (irq_o[c] === 1'b1) hc[c]++; else hc[c] = 0;
         case (amode[c])
            1: a[c] = (hc[c] >= 4);
            2: a[c] = 1'b1;
            3: a[c] = ($urandom_range(0, 3) == 0);
            default: a[c] = 1'b0;
         endcase
      end
      ack_i = a;
   end

   task automatic step(int n);
      repeat (n) @(negedge clk_i);
      #1;
   endtask

   task automatic chk(string name, longint act, longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_ni = 1'b1;
      #1;
      chk("rst_irq", irq_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_active", active_o, 0);
      chk("rst_cnt", irq_cnt_o, 0);
      step(2);
      rst_ni = 1'b0;
   endtask

   task automatic wait_level(int c, bit v, int budget);
      int n;
      n = 0;
      while (irq_o[c] !== v && n < budget) begin step(1); n++; end
      if (irq_o[c] !== v) begin
         checks++; errors++;
         $display("FAIL wait_irq%0d: got %0b after %0d cycles, expected %0b", c, irq_o[c], budget, v);
      end
   endtask

   // rise-to-rise gaps on one channel must stay inside [lo,hi]
   task automatic measure(int c, int n, int lo, int hi);
      int last, got, budget;
      bit was;
      last = -1; got = 0; budget = 0; was = irq_o[c];
      while (got < n && budget < 2000) begin
         step(1); budget++;
         if (irq_o[c] && !was) begin
            if (last >= 0) begin
               checks++;
               if (cyc - last < lo || cyc - last > hi) begin
                  errors++;
                  $display("FAIL gap_ch%0d: got %0d expected %0d..%0d", c, cyc - last, lo, hi);
               end
            end
            last = cyc; got++;
         end
         was = irq_o[c];
      end
      chk("gap_rises", got, n);
   endtask

   function automatic longint exp_cnt();
`ifdef TB_INTR_GEN_CNT_EN
      return mcount;
`else
      return 0;
`endif
   endfunction

   initial begin
      int r;
      for (int c = 0; c < NCH; c++) amode[c] = 0;
      step(3);
      do_reset();

      // idle with every channel off, random acks must do nothing
      en_i = 1'b1; intvl_i = '0;
      for (int c = 0; c < NCH; c++) amode[c] = 3;
      step(500);
      chk("idle_irq", irq_o, 0);
      chk("idle_err", err_o, 0);
      chk("idle_active", active_o, 0);

      // level mode, acked after the line has been high 4 cycles: gap = D + 5
      for (int c = 0; c < NCH; c++) amode[c] = 0;
      intvl_i = 12'h001; mode_i = 3'b000; amode[0] = 1;
      measure(0, 8, 21, 36);

      // pulse mode with ack tied high: gap = D + PW + 1
      intvl_i = 12'h020; mode_i = 3'b010; amode[1] = 2;
      measure(1, 8, 37, 52);

      // disable during WAIT
      intvl_i = '0; en_i = 1'b0;
      do_reset();
      intvl_i = 12'h001; mode_i = 3'b000; amode[0] = 1; amode[1] = 0; en_i = 1'b1;
      step(5);
      chk("dis_wait_active", active_o, 1);
      en_i = 1'b0;
      step(1);
      chk("dis_wait_idle", active_o, 0);
      step(60);
      chk("dis_wait_noirq", irq_o[0], 0);

      // disable during level ASSERT: held until ack
      amode[0] = 0; en_i = 1'b1;
      wait_level(0, 1'b1, 300);
      en_i = 1'b0;
      step(20);
      chk("dis_assert_held", irq_o[0], 1);
      amode[0] = 1;
      wait_level(0, 1'b0, 20);
      step(3);
      chk("dis_assert_idle", active_o, 0);

      // ack timeout on ch2
      intvl_i = '0;
      do_reset();
      intvl_i = 12'h100; mode_i = 3'b000; amode[2] = 0; en_i = 1'b1;
      wait_level(2, 1'b1, 300);
      r = cyc;
      step(ATO - 1);
      chk("to_err_early", err_o[2], 0);
      step(1);
      chk("to_err_cycle", cyc - r, ATO);
      chk("to_err_set", err_o[2], 1);
      chk("to_irq_held", irq_o[2], 1);
      rst_ni = 1'b1;
      #1;
      chk("to_async_irq", irq_o[2], 0);
      chk("to_async_err", err_o[2], 0);
      step(2);
      rst_ni = 1'b0;

      // counter: all channels pulsing
      intvl_i = 12'h111; mode_i = 3'b111;
      for (int c = 0; c < NCH; c++) amode[c] = 3;
      step(2000);
      chk("cnt_total", irq_cnt_o, exp_cnt());
      chk("cnt_nonzero_model", (mcount > 0) ? 1 : 0, 1);

      // random traffic
      for (int b = 0; b < 30; b++) begin
         en_i = ($urandom_range(0, 5) != 0);
         for (int c = 0; c < NCH; c++) begin
            intvl_i[4*c +: 4] = 4'($urandom_range(0, 3));
            mode_i[c] = 1'($urandom_range(0, 1));
            amode[c] = $urandom_range(0, 3);
         end
         if ($urandom_range(0, 9) == 0) do_reset();
         step($urandom_range(20, 150));
      end

      // drain
      en_i = 1'b0;
      for (int c = 0; c < NCH; c++) amode[c] = 1;
      step(300);
      chk("drain_active", active_o, 0);
      chk("drain_cnt", irq_cnt_o, exp_cnt());
      chk("drain_sb_empty", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected end of test");
      $fatal(1, "watchdog");
   end
endmodule
